// File: rtl/mac_bus_snoop_if.sv
// mac_bus_snoop_if: 68000 bus snoop inputs and SRAM write-queue handshake
// Signals: A/D/nAS/nUDS/nLDS/nWE raw 68000 bus; WVALID/WREADY handshake with
// WADDR/WDATA/nWUDS/nWLDS head entry; OVF sticky drop flag.
// slave = snooper side, master = bus/consumer side.
interface mac_bus_snoop_if;
  logic [22:0] A;
  logic [15:0] D;
  logic        nAS;
  logic        nUDS;
  logic        nLDS;
  logic        nWE;
  logic        WVALID;
  logic        WREADY;
  logic [13:0] WADDR;
  logic [15:0] WDATA;
  logic        nWUDS;
  logic        nWLDS;
  logic        OVF;
  modport slave (
    input  A, D, nAS, nUDS, nLDS, nWE, WREADY,
    output WVALID, WADDR, WDATA, nWUDS, nWLDS, OVF
  );
  modport master (
    output A, D, nAS, nUDS, nLDS, nWE, WREADY,
    input  WVALID, WADDR, WDATA, nWUDS, nWLDS, OVF
  );
endinterface

// File: rtl/mac_bus_snoop.sv
// mac_bus_snoop: captures Mac Plus framebuffer writes into a FWFT FIFO
// Ports: C25M system clock; nRST async active-low reset;
// bus (slave) 68000 A/D/nAS/nUDS/nLDS/nWE in, head entry
// WVALID/WADDR/WDATA/nWUDS/nWLDS out with WREADY in, sticky OVF out.
module mac_bus_snoop #(
  parameter logic [22:0] FB_BASE  = 23'h1FD380,
  parameter int          FB_WORDS = 10944,
  parameter int          SETTLE   = 2,
  parameter int          DEPTH    = 4
) (
  input logic            C25M,
  input logic            nRST,
  mac_bus_snoop_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  localparam logic [22:0] FB_END = FB_BASE + 23'(FB_WORDS);
  typedef enum logic [1:0] {IDLE, SETTLE_ST, SAMPLE, WAIT_END} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_as_s, r_uds_s, r_lds_s;
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  logic [31:0]   r_last;
  logic          r_ovf;
  logic          w_sas, w_ds, w_qual, w_full, w_valid, w_pop, w_push;
  logic [13:0]   w_off;
  logic [31:0]   w_head;
  assign w_sas   = r_as_s[1];
  assign w_ds    = ~r_uds_s[1] | ~r_lds_s[1];
  assign w_off   = 14'(bus.A - FB_BASE);
  // A/D/strobes are taken raw here: by SAMPLE they have settled for SETTLE cycles
  assign w_qual  = r_state == SAMPLE && !bus.nWE && bus.A >= FB_BASE && bus.A < FB_END
                   && !(bus.nUDS && bus.nLDS);
  assign w_full  = r_count == (AW+1)'(DEPTH);
  assign w_valid = r_count != '0;
  assign w_pop   = w_valid && bus.WREADY;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_push  = w_qual && (!w_full || w_pop);
  // empty FIFO keeps presenting the last popped entry
  assign w_head  = w_valid ? r_mem[r_rd] : r_last;
  assign bus.WVALID = w_valid;
  assign bus.WADDR  = w_head[31:18];
  assign bus.WDATA  = w_head[17:2];
  assign bus.nWUDS  = w_head[1];
  assign bus.nWLDS  = w_head[0];
  assign bus.OVF    = r_ovf;
  always_ff @(posedge C25M or negedge nRST) begin
    if (!nRST) begin
      r_as_s  <= 2'b11;
      r_uds_s <= 2'b11;
      r_lds_s <= 2'b11;
    end else begin
      r_as_s  <= {r_as_s[0], bus.nAS};
      r_uds_s <= {r_uds_s[0], bus.nUDS};
      r_lds_s <= {r_lds_s[0], bus.nLDS};
    end
  end
  always_ff @(posedge C25M or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (!w_sas && w_ds) begin
          r_state <= SETTLE_ST;
          r_cnt   <= CW'(SETTLE - 1);
        end
        SETTLE_ST: if (w_sas) r_state <= IDLE;
          else if (r_cnt == '0) r_state <= SAMPLE;
          else r_cnt <= r_cnt - 1'b1;
        SAMPLE: r_state <= WAIT_END;
        default: if (w_sas) r_state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge C25M) begin
    if (w_push) r_mem[r_wr] <= {w_off, bus.D, bus.nUDS, bus.nLDS};
  end
  always_ff @(posedge C25M or negedge nRST) begin
    if (!nRST) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_last  <= {14'd0, 16'd0, 2'b11};
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) begin
        r_rd   <= r_rd + 1'b1;
        r_last <= r_mem[r_rd];
      end
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_qual && !w_push) r_ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mac_bus_snoop.sv
// tb_mac_bus_snoop: scoreboard bench for mac_bus_snoop
module tb_mac_bus_snoop;
  typedef struct packed {
    logic [13:0] addr;
    logic [15:0] data;
    logic        u;
    logic        l;
  } ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  mac_bus_snoop_if bus();
  mac_bus_snoop dut (.C25M(clk), .nRST(rst_n), .bus(bus));
  always #20 clk = ~clk;
  ent_t exp_q[$];
  int n_vec = 0, n_err = 0, n_pop = 0, cyc = 0, t_drive = 0, lat = 0;
  bit saw_valid = 0, prev_valid = 0, exp_ovf = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.WVALID && !prev_valid) lat = cyc - t_drive;
      if (bus.WVALID) saw_valid = 1;
      if (bus.WVALID && bus.WREADY) begin
        n_pop++;
        if (exp_q.size() == 0) check("unexpected_entry", 32'd1, 32'd0);
        else begin
          ent_t e;
          e = exp_q.pop_front();
          check("waddr", 32'(bus.WADDR), 32'(e.addr));
          check("wdata", 32'(bus.WDATA), 32'(e.data));
          check("nwuds", 32'(bus.nWUDS), 32'(e.u));
          check("nwlds", 32'(bus.nWLDS), 32'(e.l));
        end
      end
    end
    prev_valid = bus.WVALID;
  end
  task automatic bus_cycle(input logic [22:0] a, input logic [15:0] d, input logic u,
                           input logic l, input logic we, input int as_hold,
                           input int ds_hold, input bit track, input bit pop_at_sample);
    ent_t e;
    int n;
    n = as_hold > ds_hold ? as_hold : ds_hold;
    if (n < 7) n = 7;
    @(posedge clk); #2;
    bus.A = a; bus.D = d; bus.nWE = we; bus.nAS = 0; bus.nUDS = u; bus.nLDS = l;
    t_drive = cyc;
    if (track && !we && a >= 23'h1FD380 && a < 23'h1FFE40 && !(u && l)) begin
      if (exp_q.size() < 4 || pop_at_sample) begin
        e.addr = 14'(a - 23'h1FD380); e.data = d; e.u = u; e.l = l;
        exp_q.push_back(e);
      end else exp_ovf = 1;
    end
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #2;
      if (i == as_hold) bus.nAS = 1;
      if (i == ds_hold) begin bus.nUDS = 1; bus.nLDS = 1; end
      if (pop_at_sample && i == 5) bus.WREADY = 1;
      if (pop_at_sample && i == 6) bus.WREADY = 0;
    end
    repeat (3) @(posedge clk);
  endtask
  task automatic drain(input string tag, input int exp_pops);
    int n0;
    n0 = n_pop;
    @(posedge clk); #2;
    bus.WREADY = 1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_pops"}, 32'(n_pop - n0), 32'(exp_pops));
    check({tag, "_wvalid"}, 32'(bus.WVALID), 32'd0);
    check({tag, "_ovf"}, 32'(bus.OVF), 32'(exp_ovf));
  endtask
  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 0;
    exp_q.delete();
    exp_ovf = 0;
    #1;
    check("rst_wvalid", 32'(bus.WVALID), 32'd0);
    check("rst_ovf", 32'(bus.OVF), 32'd0);
    check("rst_wdata", 32'(bus.WDATA), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
  endtask
  initial begin
    bus.A = '0; bus.D = '0; bus.nAS = 1; bus.nUDS = 1; bus.nLDS = 1; bus.nWE = 1;
    bus.WREADY = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_wvalid", 32'(bus.WVALID), 32'd0);
    check("reset_ovf", 32'(bus.OVF), 32'd0);
    check("reset_waddr", 32'(bus.WADDR), 32'd0);
    check("reset_wdata", 32'(bus.WDATA), 32'd0);
    check("reset_nwuds", 32'(bus.nWUDS), 32'd1);
    check("reset_nwlds", 32'(bus.nWLDS), 32'd1);
    @(posedge clk); #2 rst_n = 1;
    bus_cycle(23'h1FD380, 16'hA5C3, 0, 0, 0, 8, 8, 1, 0);
    check("latency_word", 32'(lat), 32'd6);
    drain("word", 0);
    check("hold_wdata", 32'(bus.WDATA), 32'hA5C3);
    bus_cycle(23'h1FFE3F, 16'h1234, 1, 0, 0, 8, 8, 1, 0);
    drain("edge_hi", 0);
    check("hold_waddr_edge", 32'(bus.WADDR), 32'h2ABF);
    check("hold_nwuds_edge", 32'(bus.nWUDS), 32'd1);
    saw_valid = 0;
    bus_cycle(23'h1FFE40, 16'h5555, 0, 0, 0, 8, 8, 1, 0);
    bus_cycle(23'h1FD37F, 16'h6666, 0, 0, 0, 8, 8, 1, 0);
    check("no_push_outside", 32'(saw_valid), 32'd0);
    saw_valid = 0;
    bus_cycle(23'h1FD3A0, 16'h7777, 0, 0, 1, 20, 20, 1, 0);
    check("no_push_read", 32'(saw_valid), 32'd0);
    lat = 0;
    bus_cycle(23'h1FD390, 16'hBEEF, 0, 0, 0, 8, 8, 1, 0);
    check("latency_after_read", 32'(lat), 32'd6);
    drain("after_read", 0);
    saw_valid = 0;
    bus_cycle(23'h1FD3A0, 16'hCAFE, 0, 0, 0, 2, 8, 0, 0);
    check("no_push_abort", 32'(saw_valid), 32'd0);
    bus.WREADY = 0;
    for (int k = 1; k <= 5; k++) bus_cycle(23'h1FD380 + 23'(k), 16'(k), 0, 0, 0, 8, 8, 1, 0);
    check("ovf_set", 32'(bus.OVF), 32'd1);
    check("ovf_head_valid", 32'(bus.WVALID), 32'd1);
    drain("ovf", 4);
    do_reset();
    bus.WREADY = 0;
    for (int k = 0; k < 4; k++) bus_cycle(23'h1FD400 + 23'(k), 16'h10 + 16'(k), 0, 0, 0, 8, 8, 1, 0);
    bus_cycle(23'h1FD404, 16'h0014, 0, 1, 0, 8, 8, 1, 1);
    check("pushpop_ovf", 32'(bus.OVF), 32'd0);
    check("pushpop_valid", 32'(bus.WVALID), 32'd1);
    drain("pushpop", 4);
    bus.WREADY = 0;
    for (int k = 0; k < 3; k++) bus_cycle(23'h1FD500 + 23'(k), 16'h20 + 16'(k), 0, 0, 0, 8, 8, 1, 0);
    check("queued_valid", 32'(bus.WVALID), 32'd1);
    do_reset();
    saw_valid = 0;
    bus.WREADY = 1;
    repeat (10) @(negedge clk);
    check("no_stale_entry", 32'(saw_valid), 32'd0);
    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
